// File: rtl/pcpi_result_nibble_tx.sv
// Nibble-serial transmitter for coprocessor result words: shifts a word out
// least-significant nibble first, one valid/ack handshake per nibble.
module pcpi_result_nibble_tx #(
  parameter int WORD_W = 32,
  parameter int NIB_W = 4,
  localparam int NIBBLES = WORD_W / NIB_W,
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_res_valid,
  input  logic [WORD_W-1:0] i_res_data,
  output logic              o_res_ready,
  output logic              o_tx_valid,
  output logic [NIB_W-1:0]  o_tx_nibble,
  output logic              o_tx_last,
  output logic [IDX_W-1:0]  o_tx_idx,
  input  logic              i_tx_ack,
  output logic              o_word_done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  logic [1:0]        r_state;
  logic [WORD_W-1:0] r_shreg;
  logic [IDX_W-1:0]  r_idx;
  logic              r_wordDone;

  logic w_send;
  logic w_lastIdx;

  assign w_send    = (r_state == S_SEND);
  assign w_lastIdx = (r_idx == LAST_IDX);

  // The GAP state forces one tx_valid=0 cycle after every ack so a receiver
  // that samples the valid level cannot capture the same nibble twice.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_shreg    <= '0;
      r_idx      <= '0;
      r_wordDone <= 1'b0;
    end else begin
      r_wordDone <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_res_valid) begin
            r_shreg <= i_res_data;
            r_idx   <= '0;
            r_state <= S_SEND;
          end
        end
        S_SEND: begin
          if (i_tx_ack) begin
            if (w_lastIdx) begin
              r_state    <= S_IDLE;
              r_wordDone <= 1'b1;
            end else begin
              r_shreg <= r_shreg >> NIB_W;
              r_idx   <= r_idx + IDX_W'(1);
              r_state <= S_GAP;
            end
          end
        end
        S_GAP: begin
          r_state <= S_SEND;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_res_ready = (r_state == S_IDLE);
  assign o_tx_valid  = w_send;
  assign o_tx_nibble = w_send ? r_shreg[NIB_W-1:0] : '0;
  assign o_tx_last   = w_send & w_lastIdx;
  assign o_tx_idx    = r_idx;
  assign o_word_done = r_wordDone;

endmodule

// File: doc/pcpi_result_nibble_tx.md
# pcpi_result_nibble_tx

Nibble-serial transmitter for 32-bit coprocessor results. It is the return path for the nibble-serial instruction loader. It accepts one result word from the PCPI-side logic and shifts it off-chip four bits at a time, least-significant nibble first. Each nibble uses a level-valid / single-cycle-ack handshake, the mirror of the loader's sending/received exchange. It sits between the coprocessor result port and the dedicated output pins.

## Interface

Parameters:
- WORD_W, default 32: result word width; must be a multiple of NIB_W.
- NIB_W, default 4: nibble width.
- Derived: NIBBLES = WORD_W/NIB_W (8); IDX_W = clog2(NIBBLES) (3).

Ports:
- clk  in  1  sole clock; everything is on the rising edge.
- rst  in  1  reset, synchronous and active-high. All state is cleared on the edge where rst=1.
- res_valid  in  1  result word available on res_data.
- res_data  in  WORD_W  result word; sampled only on acceptance.
- res_ready  out  1  transmitter idle and able to accept a word; equals (state==IDLE).
- tx_valid  out  1  tx_nibble is valid and awaiting ack.
- tx_nibble  out  NIB_W  current nibble.
- tx_last  out  1  high with tx_valid on the final nibble (idx==NIBBLES-1).
- tx_idx  out  IDX_W  index of the current nibble, 0 = bits [3:0].
- tx_ack  in  1  receiver has taken tx_nibble; single-cycle pulse or level, both legal.
- word_done  out  1  one-cycle pulse after the final nibble is acked.

## Operation

- State machine IDLE → SEND → GAP → SEND … → IDLE. State, shift register, idx and word_done are registered. res_ready, tx_valid, tx_nibble and tx_last decode from registers with no input-to-output combinational path.
- IDLE:
  - Outputs: tx_valid=0, res_ready=1.
  - If res_valid=1, load res_data into the shift register, set idx=0 and go to SEND.
- SEND:
  - Outputs: tx_valid=1, tx_nibble=shreg[NIB_W-1:0], tx_last=(idx==NIBBLES-1).
  - tx_ack=0: hold, with all outputs stable.
  - tx_ack=1 and not last: shift shreg right by NIB_W (zero fill), idx+1, go to GAP.
  - tx_ack=1 and last: go to IDLE, with word_done=1 in the next cycle.
- GAP:
  - tx_valid=0 for exactly one cycle, then go to SEND.
  - The gap stops a receiver that samples the valid level from double-capturing one nibble.
- tx_ack is ignored in IDLE and GAP.
- res_valid is ignored outside IDLE. A word held on res_valid is accepted in the IDLE cycle that follows word_done.
- No arithmetic beyond the idx increment, which never wraps mid-word. idx resets to 0 on load.
- When tx_valid=0, tx_nibble and tx_last are driven to 0 and tx_idx holds.

## Timing

- Reset values: tx_valid=0, tx_nibble=0, tx_last=0, tx_idx=0, word_done=0, res_ready=1, shift register=0, state=IDLE.
- Accept at edge k (IDLE, res_valid=1): nibble 0 is valid from cycle k+1.
- Ack sampled at edge m while in SEND: tx_valid=0 in cycle m+1, and the next nibble is valid in cycle m+2.
- Minimum word time, with ack held high: 8 SEND cycles + 7 GAP cycles = 15 cycles. word_done is high in cycle 16, which is also an IDLE cycle. The next word can be accepted at that edge.
- Back-to-back words always have at least one tx_valid=0 cycle between the last nibble and the next word's nibble 0.
- rst=1 mid-word: the partial word is discarded, outputs return to reset values on the next cycle, and no word_done is issued.
- rst and res_valid together: rst wins.

## Test plan

- Reset: hold rst for 2 cycles with random inputs → tx_valid=0, tx_nibble=0, word_done=0, res_ready=1.
- Basic word: send res_data=0x89ABCDEF and pulse tx_ack one cycle after each tx_valid rise → nibbles F,E,D,C,B,A,9,8 with tx_idx 0..7. tx_last is high only on 8. Exactly one word_done pulse.
- Ack held high: send 0x12345678 with tx_ack=1 constantly → tx_valid alternates 1,0 and each nibble 8,7,6,5,4,3,2,1 appears for one cycle. word_done occurs 16 cycles after acceptance.
- Busy backpressure: assert res_valid with 0xAAAA5555, then change res_data to 0xDEADBEEF while the first word is sending → res_ready=0 throughout and the first word transmits unchanged. 0xDEADBEEF is accepted on the word_done cycle.
- Stray ack: pulse tx_ack in IDLE and in GAP → no idx advance and no nibble skipped; the full 8-nibble sequence is intact.
- Reset mid-word: assert rst after 3 nibbles are acked → tx_valid=0 next cycle and no word_done. A new word 0x0F0F0F0F then starts at tx_idx=0 with nibble F.
